pixel_digital_scan: RTL and testbench

PIXEL_DIGITAL_SCAN -- requirements
Module: pixel_digital_scan

---
 rtl/pixel_digital_scan.sv | 93 +++++++++
 tb/tb_pixel_digital_scan.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/pixel_digital_scan.sv
// rtl/pixel_digital_scan.sv - free-running row/column-group scan sequencer for a pixel array
module pixel_digital_scan #(
    parameter int ROW           = 400,
    parameter int COLUMN        = 32,
    parameter int ROW_CNT_WIDTH = 9,
    parameter int COL_CNT_WIDTH = 5
) (
    input  logic                   clk_s,
    input  logic                   rst_s,
    input  logic                   start_s,
    input  logic                   speak_s,
    output logic                   marker_a,
    output logic [ROW-1:0]         rowSel,
    output logic [COLUMN*32-1:0]   columnSel
);

    localparam int RW   = (ROW_CNT_WIDTH > $clog2(ROW)) ? ROW_CNT_WIDTH : $clog2(ROW);
    localparam int CW   = (COL_CNT_WIDTH > $clog2(COLUMN)) ? COL_CNT_WIDTH : $clog2(COLUMN);
    localparam int SELW = COLUMN * 32;

    localparam logic [RW-1:0] R_LAST = RW'(ROW - 1);
    localparam logic [CW-1:0] C_LAST = CW'(COLUMN - 1);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t          state, state_n;
    logic [RW-1:0]   r, r_n;
    logic [CW-1:0]   c, c_n;
    logic            mark_n;
    logic [ROW-1:0]  row_n;
    logic [SELW-1:0] col_n;

    always_ff @(posedge clk_s or posedge rst_s) begin
        if (rst_s) begin
            state <= IDLE;
            r     <= '0;
            c     <= '0;
        end else begin
            state <= state_n;
            r     <= r_n;
            c     <= c_n;
        end
    end

    // Marker fires only on entry to (0,0): a restart or the end-of-frame wrap.
    always_comb begin
        state_n = state;
        r_n     = r;
        c_n     = c;
        mark_n  = 1'b0;
        if (start_s) begin
            state_n = SCAN;
            r_n     = '0;
            c_n     = '0;
            mark_n  = 1'b1;
        end else if (state == SCAN && speak_s) begin
            if (c == C_LAST) begin
                c_n = '0;
                if (r == R_LAST) begin
                    r_n    = '0;
                    mark_n = 1'b1;
                end else begin
                    r_n = r + 1'b1;
                end
            end else begin
                c_n = c + 1'b1;
            end
        end
    end

    always_comb begin
        row_n = ROW'(1) << r_n;
        col_n = SELW'({32{1'b1}}) << {c_n, 5'b0};
    end

    // Selects are decoded from the next position so they sit directly on flops.
    always_ff @(posedge clk_s or posedge rst_s) begin
        if (rst_s) begin
            rowSel    <= '0;
            columnSel <= '0;
            marker_a  <= 1'b0;
        end else if (state_n == SCAN) begin
            rowSel    <= row_n;
            columnSel <= col_n;
            marker_a  <= mark_n;
        end else begin
            rowSel    <= '0;
            columnSel <= '0;
            marker_a  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pixel_digital_scan.sv
// tb/tb_pixel_digital_scan.sv - scoreboard bench for pixel_digital_scan
module tb_pixel_digital_scan;

    localparam int ROW    = 400;
    localparam int COLUMN = 32;
    localparam int FRAME  = ROW * COLUMN;

    logic                 clk_s = 1'b0;
    logic                 rst_s;
    logic                 start_s;
    logic                 speak_s;
    logic                 marker_a;
    logic [ROW-1:0]       rowSel;
    logic [COLUMN*32-1:0] columnSel;

    pixel_digital_scan #(
        .ROW(ROW), .COLUMN(COLUMN), .ROW_CNT_WIDTH(9), .COL_CNT_WIDTH(5)
    ) dut (
        .clk_s(clk_s), .rst_s(rst_s), .start_s(start_s), .speak_s(speak_s),
        .marker_a(marker_a), .rowSel(rowSel), .columnSel(columnSel)
    );

    always #5 clk_s = ~clk_s;

    typedef struct {
        logic  act;
        int    r;
        int    c;
        logic  m;
        string name;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   pos    = 0;

    function automatic int first_one_row();
        for (int i = 0; i < ROW; i++) if (rowSel[i]) return i;
        return -1;
    endfunction

    function automatic int first_one_col();
        for (int i = 0; i < COLUMN * 32; i++) if (columnSel[i]) return i;
        return -1;
    endfunction

    task automatic compare(input exp_t e);
        logic [ROW-1:0]       er;
        logic [COLUMN*32-1:0] ec;
        er = '0;
        ec = '0;
        if (e.act) begin
            er[e.r] = 1'b1;
            for (int b = 0; b < 32; b++) ec[e.c * 32 + b] = 1'b1;
        end
        checks++;
        if (rowSel !== er || columnSel !== ec || marker_a !== e.m) begin
            errors++;
            $display("FAIL %s: got marker=%b row_first=%0d row_ones=%0d col_first=%0d col_ones=%0d, expected marker=%b active=%b row=%0d group=%0d",
                     e.name, marker_a, first_one_row(), $countones(rowSel), first_one_col(),
                     $countones(columnSel), e.m, e.act, e.r, e.c);
        end
    endtask

    // Monitor: every driven cycle has exactly one expectation queued.
    initial begin
        forever begin
            @(posedge clk_s);
            #2;
            if (q.size() > 0) compare(q.pop_front());
        end
    end

    task automatic step(input logic st, input logic sp, input string nm,
                        input logic act, input int r, input int c, input logic m);
        exp_t e;
        @(negedge clk_s);
        start_s = st;
        speak_s = sp;
        e.act = act; e.r = r; e.c = c; e.m = m; e.name = nm;
        q.push_back(e);
    endtask

    task automatic advance(input int n, input string nm);
        for (int i = 0; i < n; i++) begin
            pos = (pos + 1) % FRAME;
            step(1'b0, 1'b1, nm, 1'b1, pos / COLUMN, pos % COLUMN, pos == 0);
        end
    endtask

    task automatic check_zero(input string nm);
        checks++;
        if (rowSel !== '0 || columnSel !== '0 || marker_a !== 1'b0) begin
            errors++;
            $display("FAIL %s: got marker=%b row_ones=%0d col_ones=%0d, expected all zero",
                     nm, marker_a, $countones(rowSel), $countones(columnSel));
        end
    endtask

    initial begin
        rst_s   = 1'b1;
        start_s = 1'b0;
        speak_s = 1'b0;
        #1;
        check_zero("reset_state");
        repeat (3) @(posedge clk_s);
        @(negedge clk_s);
        rst_s = 1'b0;

        for (int i = 0; i < 100; i++) step(1'b0, 1'b1, "idle_no_start", 1'b0, 0, 0, 1'b0);

        step(1'b1, 1'b0, "start_first", 1'b1, 0, 0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, "hold_after_start", 1'b1, 0, 0, 1'b0);

        step(1'b0, 1'b1, "adv_c1", 1'b1, 0, 1, 1'b0);
        step(1'b0, 1'b1, "adv_c2", 1'b1, 0, 2, 1'b0);
        pos = 2;
        advance(29, "adv_row0");
        step(1'b0, 1'b1, "row_wrap_r1", 1'b1, 1, 0, 1'b0);
        step(1'b0, 1'b1, "adv_r1_c1", 1'b1, 1, 1, 1'b0);
        pos = 33;
        step(1'b0, 1'b0, "hold_mid", 1'b1, 1, 1, 1'b0);

        advance(FRAME - 1 - pos, "run_to_last");
        step(1'b0, 1'b1, "frame_wrap", 1'b1, 0, 0, 1'b1);
        pos = 0;
        step(1'b0, 1'b0, "hold_at_origin", 1'b1, 0, 0, 1'b0);
        step(1'b0, 1'b0, "hold_at_origin2", 1'b1, 0, 0, 1'b0);

        advance(5 * COLUMN + 3, "run_to_r5");
        step(1'b1, 1'b0, "restart_mid", 1'b1, 0, 0, 1'b1);
        pos = 0;
        advance(4, "after_restart");
        step(1'b1, 1'b1, "start_beats_speak", 1'b1, 0, 0, 1'b1);
        pos = 0;
        advance(40, "before_reset");

        @(posedge clk_s);
        #4;
        rst_s = 1'b1;
        #1;
        check_zero("async_reset");
        @(negedge clk_s);
        start_s = 1'b1;
        speak_s = 1'b1;
        @(posedge clk_s);
        #1;
        check_zero("start_during_reset");
        @(negedge clk_s);
        start_s = 1'b0;
        rst_s   = 1'b0;
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, "idle_after_reset", 1'b0, 0, 0, 1'b0);
        step(1'b1, 1'b0, "start_after_reset", 1'b1, 0, 0, 1'b1);
        step(1'b0, 1'b1, "adv_after_reset", 1'b1, 0, 1, 1'b0);

        @(negedge clk_s);
        start_s = 1'b0;
        speak_s = 1'b0;
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk_s);
        if (q.size() > 0) begin
            errors++;
            checks++;
            $display("FAIL drain: got %0d pending, expected 0", q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
